// File: rtl/d_cache_sa.sv
// d_cache_sa: set-associative, write-through, no-write-allocate data cache
// between the core's sram-like data port and the AXI bridge's sram-like port.
//
// Lines of LINE_WORDS words are refilled one word per memory transaction.
// One or two ways per set; with two ways a per-set LRU bit names the way to
// evict next. The core-side handshake keeps the meaning of the earlier
// direct-mapped, one-word-per-line cache.
//
// Parameters:
//   INDEX_WIDTH  : set index bits (SETS = 2**INDEX_WIDTH)
//   OFFSET_WIDTH : byte offset bits (LINE_WORDS = 2**(OFFSET_WIDTH-2))
//   WAYS         : associativity, 1 or 2
//
// Ports:
//   clk, resetn               : clock, asynchronous active-low reset
//   cpu_data_req/wr/size/addr/wdata : core request (size 00 byte, 01 half, 10 word)
//   cpu_data_rdata            : load data, valid with cpu_data_data_ok
//   cpu_data_addr_ok          : request accepted (only in IDLE)
//   cpu_data_data_ok          : request complete
//   cache_data_req/wr/size/addr/wdata : memory request
//   cache_data_rdata          : memory load data
//   cache_data_addr_ok        : memory accepted the request
//   cache_data_data_ok        : memory completed the request
//
// Optional feature macro: DCACHE_UNCACHED_KSEG1_EN
//   When defined, addresses with addr[31:29] == 3'b101 bypass the cache:
//   reads go through the UREAD state as a single memory read, writes take
//   the WRITE path without touching any line.
//
// Handshake (both sides): a request is transferred on a rising edge where
// req and addr_ok are both high; it completes on a rising edge where
// data_ok is high. addr_ok and data_ok may be high in the same cycle, in
// which case the request is both accepted and completed on that edge. At
// most one memory transaction is outstanding. The current FSM state is held
// in the register named `state` for observation.

module d_cache_sa #(
  parameter int INDEX_WIDTH  = 7,
  parameter int OFFSET_WIDTH = 4,
  parameter int WAYS         = 2
) (
  input  logic        clk,
  input  logic        resetn,
  // core side
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  // memory side
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);

  localparam int TAG_WIDTH  = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int LINE_WORDS = 1 << (OFFSET_WIDTH - 2);
  // Word counter / word select width; kept at least one bit wide so a
  // one-word line still has a legal (always zero) counter.
  localparam int WB         = (OFFSET_WIDTH > 2) ? OFFSET_WIDTH - 2 : 1;
  localparam logic [WB-1:0] LAST_WORD = WB'(LINE_WORDS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REFILL = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
`ifdef DCACHE_UNCACHED_KSEG1_EN
  localparam logic [2:0] S_UREAD  = 3'd4;
`endif

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [2:0]    state;
  logic          req_pend;   // memory request raised but not yet accepted
  logic [WB-1:0] cnt;        // refill word counter
  logic          victim_q;   // way being refilled
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;

  logic [SETS-1:0]      valid [WAYS];
  logic [SETS-1:0]      lru;          // way to evict next (two-way only)
  logic [TAG_WIDTH-1:0] tag_mem  [WAYS][SETS];
  logic [31:0]          data_mem [WAYS][SETS][LINE_WORDS];

  // ---------------------------------------------------------------------
  // Address fields
  // ---------------------------------------------------------------------
  function automatic logic [WB-1:0] word_of(input logic [31:0] a);
    if (LINE_WORDS == 1) return '0;
    else                 return a[WB+1:2];
  endfunction

  logic [INDEX_WIDTH-1:0] in_set, q_set;
  logic [TAG_WIDTH-1:0]   in_tag, q_tag;
  logic [WB-1:0]          in_word, q_word;

  assign in_set  = cpu_data_addr[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign in_tag  = cpu_data_addr[31:INDEX_WIDTH+OFFSET_WIDTH];
  assign in_word = word_of(cpu_data_addr);
  assign q_set   = addr_q[INDEX_WIDTH+OFFSET_WIDTH-1:OFFSET_WIDTH];
  assign q_tag   = addr_q[31:INDEX_WIDTH+OFFSET_WIDTH];
  assign q_word  = word_of(addr_q);

  // ---------------------------------------------------------------------
  // Lookup and victim choice on the incoming address. Ways are scanned from
  // the top down so way 0 wins among hits and among invalid ways.
  // ---------------------------------------------------------------------
  logic hit;
  logic hit_way;
  logic victim;

  always_comb begin
    hit     = 1'b0;
    hit_way = 1'b0;
    victim  = (WAYS == 2) ? lru[in_set] : 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid[w][in_set] && (tag_mem[w][in_set] == in_tag)) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
      if (!valid[w][in_set]) victim = 1'(w);
    end
  end

  logic [31:0] hit_word;
  assign hit_word = data_mem[hit_way][in_set][in_word];

  // Store merge into the hit word.
  logic [3:0]  byte_mask;
  logic [31:0] merged;

  always_comb begin
    case (cpu_data_size)
      2'b00:   byte_mask = 4'b0001 << cpu_data_addr[1:0];
      2'b01:   byte_mask = cpu_data_addr[1] ? 4'b1100 : 4'b0011;
      2'b10:   byte_mask = 4'b1111;
      default: byte_mask = 4'b0000;
    endcase
    merged = hit_word;
    for (int b = 0; b < 4; b++) begin
      if (byte_mask[b]) merged[8*b +: 8] = cpu_data_wdata[8*b +: 8];
    end
  end

  // ---------------------------------------------------------------------
  // Control terms
  // ---------------------------------------------------------------------
  logic uncached;
`ifdef DCACHE_UNCACHED_KSEG1_EN
  assign uncached = (cpu_data_addr[31:29] == 3'b101);
`else
  assign uncached = 1'b0;
`endif

  logic accept, cacheable, rd_hit, wr_hit, mem_done, fill_beat, fill_last;

  // resetn gates acceptance so every output is 0 while reset is held.
  assign accept    = resetn && (state == S_IDLE) && cpu_data_req;
  assign cacheable = accept && !uncached;
  assign rd_hit    = cacheable && !cpu_data_wr && hit;
  assign wr_hit    = cacheable &&  cpu_data_wr && hit;
  // A data_ok only counts for a transaction already accepted, or one being
  // accepted in the same cycle.
  assign mem_done  = cache_data_data_ok && (!req_pend || cache_data_addr_ok);
  assign fill_beat = (state == S_REFILL) && mem_done;
  assign fill_last = fill_beat && (cnt == LAST_WORD);

  logic [31:0] refill_addr;
  assign refill_addr = {addr_q[31:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}}
                     | {{(30 - WB){1'b0}}, cnt, 2'b00};

  // ---------------------------------------------------------------------
  // FSM, valid and LRU bits
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      req_pend <= 1'b0;
      cnt      <= '0;
      victim_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      lru      <= '0;
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            addr_q  <= cpu_data_addr;
            wdata_q <= cpu_data_wdata;
            size_q  <= cpu_data_size;
            if (cpu_data_wr) begin
              state    <= S_WRITE;
              req_pend <= 1'b1;
              if (wr_hit && (WAYS == 2)) lru[in_set] <= ~hit_way;
`ifdef DCACHE_UNCACHED_KSEG1_EN
            end else if (uncached) begin
              state    <= S_UREAD;
              req_pend <= 1'b1;
`endif
            end else if (rd_hit) begin
              if (WAYS == 2) lru[in_set] <= ~hit_way;
            end else begin
              // Read miss: the victim line is invalid until fully refilled.
              state                 <= S_REFILL;
              req_pend              <= 1'b1;
              cnt                   <= '0;
              victim_q              <= victim;
              valid[victim][in_set] <= 1'b0;
            end
          end
        end

        S_REFILL: begin
          if (mem_done) begin
            if (cnt == LAST_WORD) begin
              cnt                    <= '0;
              req_pend               <= 1'b0;
              valid[victim_q][q_set] <= 1'b1;
              if (WAYS == 2) lru[q_set] <= ~victim_q;
              state                  <= S_DONE;
            end else begin
              cnt      <= cnt + WB'(1);
              req_pend <= 1'b1;
            end
          end else if (req_pend && cache_data_addr_ok) begin
            req_pend <= 1'b0;
          end
        end

`ifdef DCACHE_UNCACHED_KSEG1_EN
        S_UREAD,
`endif
        S_WRITE: begin
          if (mem_done) begin
            state    <= S_IDLE;
            req_pend <= 1'b0;
          end else if (req_pend && cache_data_addr_ok) begin
            req_pend <= 1'b0;
          end
        end

        S_DONE:  state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

  // Line storage carries no reset; valid bits guard every use.
  always_ff @(posedge clk) begin
    if (wr_hit)    data_mem[hit_way][in_set][in_word] <= merged;
    if (fill_beat) data_mem[victim_q][q_set][cnt]     <= cache_data_rdata;
    if (fill_last) tag_mem[victim_q][q_set]           <= q_tag;
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  always_comb begin
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = 32'h0;
    cache_data_req   = 1'b0;
    cache_data_wr    = 1'b0;
    cache_data_size  = 2'b00;
    cache_data_addr  = 32'h0;
    cache_data_wdata = 32'h0;
    case (state)
      S_IDLE: begin
        cpu_data_addr_ok = accept;
        if (rd_hit) begin
          cpu_data_data_ok = 1'b1;
          cpu_data_rdata   = hit_word;
        end
      end
      S_REFILL: begin
        cache_data_req  = req_pend;
        cache_data_size = 2'b10;
        cache_data_addr = req_pend ? refill_addr : 32'h0;
      end
      S_WRITE: begin
        cache_data_req   = req_pend;
        cache_data_wr    = req_pend;
        cache_data_size  = req_pend ? size_q : 2'b00;
        cache_data_addr  = req_pend ? addr_q : 32'h0;
        cache_data_wdata = req_pend ? wdata_q : 32'h0;
        cpu_data_data_ok = mem_done;
      end
      S_DONE: begin
        cpu_data_data_ok = 1'b1;
        cpu_data_rdata   = data_mem[victim_q][q_set][q_word];
      end
`ifdef DCACHE_UNCACHED_KSEG1_EN
      S_UREAD: begin
        cache_data_req   = req_pend;
        cache_data_size  = req_pend ? size_q : 2'b00;
        cache_data_addr  = req_pend ? addr_q : 32'h0;
        cpu_data_data_ok = mem_done;
        cpu_data_rdata   = mem_done ? cache_data_rdata : 32'h0;
      end
`endif
      default: ;
    endcase
  end

endmodule
